// File: rtl/bch_pkg.sv
// Shared types, constants and sizing helpers for the pipelined BCH encoder.
package bch_pkg;

  // Generator of the (79,64) DEC-TED code: (x+1)*m1*m3 over GF(2^7), leading x^15 implicit.
  localparam logic [14:0] BCH_79_64_GEN = 15'h4599;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_e;

  function automatic int calc_nstep(input int data_w, input int step_w);
    return data_w / step_w;
  endfunction

  function automatic int calc_cnt_w(input int nstep);
    return (nstep <= 1) ? 1 : $clog2(nstep);
  endfunction

endpackage

// File: rtl/bch_lfsr_step.sv
// Combinational multi-bit LFSR step: advances a polynomial-division remainder by STEP_W input bits.
module bch_lfsr_step
  import bch_pkg::*;
#(
  parameter int              PAR_W    = 15,
  parameter logic [PAR_W-1:0] GEN_POLY = BCH_79_64_GEN,
  parameter int              STEP_W   = 8
) (
  input  logic [PAR_W-1:0]  rem_i,
  input  logic [0:STEP_W-1] bits_i,
  output logic [PAR_W-1:0]  rem_o
);

  always_comb begin
    // NOTE: blocking assignments here so each unrolled bit sees the previous bit's result.
    rem_o = rem_i;
    for (int i = 0; i < STEP_W; i++) begin
      rem_o = {rem_o[PAR_W-2:0], 1'b0} ^ ({PAR_W{bits_i[i] ^ rem_o[PAR_W-1]}} & GEN_POLY);
    end
  end

endmodule

// File: rtl/bch_pipe_enc.sv
// Systematic BCH encoder, STEP_W bits per clock, valid/ready on both sides.
// Optional error injection mask enabled by defining BCH_PIPE_ENC_ERRINJ_EN.
module bch_pipe_enc
  import bch_pkg::*;
#(
  parameter int               DATA_W   = 64,
  parameter int               PAR_W    = 15,
  parameter logic [PAR_W-1:0] GEN_POLY = BCH_79_64_GEN,
  parameter int               STEP_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [0:DATA_W-1]         i_data,
`ifdef BCH_PIPE_ENC_ERRINJ_EN
  input  logic [0:DATA_W+PAR_W-1]   i_err_mask,
`endif
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [0:DATA_W+PAR_W-1]   o_code
);

  localparam int CODE_W = DATA_W + PAR_W;
  localparam int NSTEP  = calc_nstep(DATA_W, STEP_W);
  localparam int CNT_W  = calc_cnt_w(NSTEP);

  if ((DATA_W % STEP_W) != 0) begin : g_step_check
    $error("bch_pipe_enc: STEP_W must divide DATA_W");
  end

  state_e            state_q;
  logic [0:DATA_W-1] data_q, data_d;
  logic [PAR_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              o_valid_q;
  logic [0:CODE_W-1] o_code_q;
  logic [0:CODE_W-1] err_mask;
  logic              accept_in;
  logic              last_step;

  assign i_ready   = !reset && (state_q == IDLE || (state_q == OUT && o_ready));
  assign accept_in = i_valid && i_ready;
  assign last_step = (cnt_q == CNT_W'(NSTEP - 1));

  // Rotating the word keeps the unconsumed bits at the front and restores the original word after NSTEP steps.
  assign data_d = (data_q << STEP_W) | (data_q >> (DATA_W - STEP_W));

  bch_lfsr_step #(
    .PAR_W   (PAR_W),
    .GEN_POLY(GEN_POLY),
    .STEP_W  (STEP_W)
  ) u_lfsr_step (
    .rem_i (rem_q),
    .bits_i(data_q[0 +: STEP_W]),
    .rem_o (rem_d)
  );

`ifdef BCH_PIPE_ENC_ERRINJ_EN
  logic [0:CODE_W-1] err_mask_q;

  always_ff @(posedge clk) begin
    if (reset)          err_mask_q <= '0;
    else if (accept_in) err_mask_q <= i_err_mask;
  end

  assign err_mask = err_mask_q;
`else
  assign err_mask = '0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_code_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SHIFT: begin
          data_q <= data_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step) begin
            o_code_q  <= {rem_d, data_d} ^ err_mask;
            o_valid_q <= 1'b1;
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (o_ready) begin
            o_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A new word may arrive in IDLE or on the same edge the held codeword is taken.
      if (accept_in) begin
        data_q  <= i_data;
        rem_q   <= '0;
        cnt_q   <= '0;
        state_q <= SHIFT;
      end
    end
  end

  assign o_valid = o_valid_q;
  assign o_code  = o_code_q;

endmodule

// File: tb/tb_bch_pipe_enc.sv
// Self-checking bench for bch_pipe_enc: STEP_W = 8, 64 and 1 instances against a long-division model.
module tb_bch_pipe_enc;

  localparam int          DW  = 64;
  localparam int          PW  = 15;
  localparam int          CW  = DW + PW;
  localparam logic [14:0] GEN = 15'h4599;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          iv   [3];
  logic          ir   [3];
  logic          ov   [3];
  logic          ordy [3];
  logic [0:DW-1] id   [3];
  logic [0:CW-1] oc   [3];
`ifdef BCH_PIPE_ENC_ERRINJ_EN
  logic [0:CW-1] im   [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bch_pipe_enc #(.STEP_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .i_valid(iv[0]), .i_ready(ir[0]), .i_data(id[0]),
`ifdef BCH_PIPE_ENC_ERRINJ_EN
    .i_err_mask(im[0]),
`endif
    .o_valid(ov[0]), .o_ready(ordy[0]), .o_code(oc[0])
  );

  bch_pipe_enc #(.STEP_W(64)) u_dut64 (
    .clk(clk), .reset(reset), .i_valid(iv[1]), .i_ready(ir[1]), .i_data(id[1]),
`ifdef BCH_PIPE_ENC_ERRINJ_EN
    .i_err_mask(im[1]),
`endif
    .o_valid(ov[1]), .o_ready(ordy[1]), .o_code(oc[1])
  );

  bch_pipe_enc #(.STEP_W(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_valid(iv[2]), .i_ready(ir[2]), .i_data(id[2]),
`ifdef BCH_PIPE_ENC_ERRINJ_EN
    .i_err_mask(im[2]),
`endif
    .o_valid(ov[2]), .o_ready(ordy[2]), .o_code(oc[2])
  );

  // Textbook long division of d(x)*x^15 by the full generator (leading 1 made explicit).
  function automatic logic [14:0] model_parity(input logic [63:0] d);
    logic [78:0] w;
    logic [78:0] g;
    w = {d, 15'b0};
    g = 79'({1'b1, GEN});
    for (int i = 78; i >= 15; i--) begin
      if (w[i]) w = w ^ (g << (i - 15));
    end
    return w[14:0];
  endfunction

  function automatic logic [78:0] exp_code(input logic [63:0] d);
    return {model_parity(d), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_code(input string name, input logic [78:0] act, input logic [78:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic timeout(input string name, input int limit);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response, required within %0d cycles", name, limit);
  endtask

  // Present one word to instance k and wait for its codeword; lat counts edges after the accept edge.
  task automatic send_word(input int k, input logic [63:0] d, output logic [78:0] code, output int lat);
    int w;
    w    = 0;
    code = '0;
    lat  = -1;
    while (!ir[k] && w < 100) begin
      tick();
      w++;
    end
    if (!ir[k]) begin
      timeout("ready_wait", 100);
      return;
    end
    iv[k] = 1'b1;
    id[k] = d;
    tick();
    iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 200) begin
      tick();
      lat++;
    end
    if (!ov[k]) begin
      timeout("valid_wait", 200);
      lat = -1;
      return;
    end
    code = oc[k];
  endtask

  typedef struct {
    logic [63:0] data;
    logic [14:0] par;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [5];
    logic [78:0] code;
    logic [78:0] exp_a;
    int          lat;
    int          w;
    int          seen;
    int          nst [3];
    int          nwords [3];
    logic [63:0] d;

    tbl[0] = '{64'h0, 15'h0000};
    tbl[1] = '{64'h1, 15'h4599};
    tbl[2] = '{64'h2, 15'h4EAB};
    tbl[3] = '{64'h3, 15'h0B32};
    tbl[4] = '{64'h4, 15'h58CF};
    nst    = '{8, 1, 64};
    nwords = '{200, 1000, 500};

    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      id[k]   = '0;
`ifdef BCH_PIPE_ENC_ERRINJ_EN
      im[k]   = '0;
`endif
    end

    reset = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check_int("rst_o_valid", int'(ov[k]), 0);
      check_code("rst_o_code", oc[k], '0);
      check_int("rst_i_ready", int'(ir[k]), 0);
    end
    reset = 1'b0;
    #1;
    check_int("i_ready_after_rst", int'(ir[0]), 1);

    // Directed vectors, including single-bit x^0 and x^1 words.
    for (int i = 0; i < 5; i++) begin
      send_word(0, tbl[i].data, code, lat);
      check_code("tbl_code", code, {tbl[i].par, tbl[i].data});
      check_int("tbl_latency", lat, 8);
    end

    // Backpressure: hold o_ready low with a second word waiting.
    tick();
    ordy[0] = 1'b0;
    iv[0]   = 1'b1;
    id[0]   = 64'hDEADBEEF_01234567;
    exp_a   = exp_code(64'hDEADBEEF_01234567);
    tick();
    id[0] = 64'h0F1E2D3C_4B5A6978;
    w = 0;
    while (!ov[0] && w < 50) begin
      tick();
      w++;
    end
    check_int("bp_latency_a", w, 8);
    check_code("bp_code_a", oc[0], exp_a);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_code("bp_hold_code", oc[0], exp_a);
      check_int("bp_hold_valid", int'(ov[0]), 1);
      check_int("bp_hold_ready", int'(ir[0]), 0);
    end
    ordy[0] = 1'b1;
    #1;
    check_int("bp_release_ready", int'(ir[0]), 1);
    tick();
    iv[0] = 1'b0;
    check_int("bp_valid_drop", int'(ov[0]), 0);
    w = 0;
    while (!ov[0] && w < 50) begin
      tick();
      w++;
    end
    check_int("bp_latency_b", w, 8);
    check_code("bp_code_b", oc[0], exp_code(64'h0F1E2D3C_4B5A6978));

    // Reset in the middle of SHIFT discards the word.
    tick();
    iv[0] = 1'b1;
    id[0] = 64'hA5A5_5A5A_C3C3_3C3C;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov[0]) seen++;
    end
    check_int("rst_mid_no_valid", seen, 0);
    send_word(0, 64'h1234_5678_9ABC_DEF0, code, lat);
    check_code("rst_mid_next_code", code, exp_code(64'h1234_5678_9ABC_DEF0));
    check_int("rst_mid_next_latency", lat, 8);

`ifdef BCH_PIPE_ENC_ERRINJ_EN
    im[0] = {1'b1, 77'b0, 1'b1};
    send_word(0, 64'hFEDC_BA98_7654_3210, code, lat);
    im[0] = '0;
    check_code("errinj_code", code, exp_code(64'hFEDC_BA98_7654_3210) ^ {1'b1, 77'b0, 1'b1});
`endif

    // Random words on every instance, issued back to back.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < nwords[k]; i++) begin
        d = {$urandom, $urandom};
        send_word(k, d, code, lat);
        check_code("rand_code", code, exp_code(d));
        check_int("rand_latency", lat, nst[k]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
